// File: rtl/ex_csr_file_pkg.sv
// csr_pkg: shared definitions for the EX-stage CSR unit.
//   - CSR address constants for the machine-mode CSRs handled by ex_csr_file
//   - mstatus / mie field bit positions
//   - inst_flags bit indices for the six CSR instruction forms
//   - misa constants for RV32I / RV64I
//   - decode helpers turning the one-hot flags into an operation kind
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // mstatus fields
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie: MSIE, MTIE, MEIE are the only implemented enables
  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  // inst_flags one-hot positions
  localparam int F_CSRRC  = 37;
  localparam int F_CSRRCI = 38;
  localparam int F_CSRRS  = 39;
  localparam int F_CSRRSI = 40;
  localparam int F_CSRRW  = 41;
  localparam int F_CSRRWI = 42;

  // MXL in the top two bits, extension 'I' at bit 8
  localparam logic [31:0] MISA_RV32I = 32'h4000_0100;
  localparam logic [63:0] MISA_RV64I = 64'h8000_0000_0000_0100;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_RW,
    OP_SET,
    OP_CLR
  } csr_op_e;

  function automatic csr_op_e decode_op(input logic [47:0] flags);
    if (flags[F_CSRRW] || flags[F_CSRRWI]) return OP_RW;
    if (flags[F_CSRRS] || flags[F_CSRRSI]) return OP_SET;
    if (flags[F_CSRRC] || flags[F_CSRRCI]) return OP_CLR;
    return OP_NONE;
  endfunction

  function automatic logic is_imm_form(input logic [47:0] flags);
    return flags[F_CSRRWI] || flags[F_CSRRSI] || flags[F_CSRRCI];
  endfunction

endpackage

// File: rtl/ex_csr_file_if.sv
// ex_csr_file_if: request/result handshake between the decode side and the
// CSR unit.
//   request : in_valid/in_ready, inst_flags, rd, imm_1519 (rs1 or zimm),
//             rs1_data, imm_2031 (CSR address)
//   result  : out_valid/out_ready, rd_out, rd_data (old CSR value), out_en,
//             illegal
// master drives requests and accepts results; slave is the CSR unit.
interface ex_csr_file_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [47:0]     inst_flags;
  logic [4:0]      rd;
  logic [4:0]      imm_1519;
  logic [XLEN-1:0] rs1_data;
  logic [11:0]     imm_2031;

  logic            out_valid;
  logic            out_ready;
  logic [4:0]      rd_out;
  logic [XLEN-1:0] rd_data;
  logic            out_en;
  logic            illegal;

  modport master (
    output in_valid, inst_flags, rd, imm_1519, rs1_data, imm_2031, out_ready,
    input  in_ready, out_valid, rd_out, rd_data, out_en, illegal
  );

  modport slave (
    input  in_valid, inst_flags, rd, imm_1519, rs1_data, imm_2031, out_ready,
    output in_ready, out_valid, rd_out, rd_data, out_en, illegal
  );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit performance counter with per-half CSR write access.
//   clk, rst   : clock, asynchronous active-low reset
//   inc        : count up by one this cycle
//   wr_lo/wr_hi: load the low/high 32 bits from wdata
//   wdata      : write data, halves aligned to their counter positions
//   count      : current value
// Any write suppresses the increment for that cycle; an unwritten half holds.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [63:0] wdata,
  output logic [63:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata[31:0];
      if (wr_hi) count[63:32] <= wdata[63:32];
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/ex_csr_file.sv
// ex_csr_file: EX-stage CSR execution unit and machine-mode CSR file.
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : CSR instruction request and registered result stage
//   instret_pulse   : one instruction retired this cycle (minstret++)
//   trap_*          : take a trap, loading mepc/mcause/mtval and stacking MIE
//   mret_valid      : return from trap, unstacking MIE
//   mtvec_out, mepc_out, mie_global : registered CSR state for the pipeline
// CSR state changes at the accept edge, so a following instruction sees the
// new value with no bubble. Traps and mret block new requests in their cycle.
module ex_csr_file
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter int          HART_ID     = 0
) (
  input  logic            clk,
  input  logic            rst,
  ex_csr_file_if.slave    bus,
  input  logic            instret_pulse,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_valid,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic            mie_global
);

  typedef logic [XLEN-1:0] xlen_t;

  localparam logic [63:0] MISA_WIDE = (XLEN == 64) ? MISA_RV64I : {32'h0, MISA_RV32I};
  localparam xlen_t       MISA_VAL  = MISA_WIDE[XLEN-1:0];
  localparam xlen_t       MIE_MASK  = xlen_t'((1 << MIE_MSIE) | (1 << MIE_MTIE) | (1 << MIE_MEIE));
  localparam xlen_t       ALIGN4    = ~xlen_t'(3);

  // CSR state
  logic  mstatus_mie_q, mstatus_mpie_q;
  xlen_t mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] cycle_q, instret_q;

  // result stage
  logic  out_valid_q, out_en_q, illegal_q;
  logic [4:0] rd_out_q;
  xlen_t rd_data_q;

  // request decode
  csr_op_e     op;
  logic [11:0] addr;
  xlen_t       src, old_val, new_val, mstatus_rd;
  logic        accept, exec, wr_try, impl, read_only, illegal_c, do_write;
  logic [63:0] cnt_wdata;

  assign op     = decode_op(bus.inst_flags);
  assign addr   = bus.imm_2031;
  assign src    = is_imm_form(bus.inst_flags) ? xlen_t'(bus.imm_1519) : bus.rs1_data;
  // Set/clear with rs1 = x0 (or zimm = 0) is a pure read.
  assign wr_try = (op == OP_RW) || ((op != OP_NONE) && (bus.imm_1519 != 5'd0));

  assign bus.in_ready = !trap_valid && !mret_valid && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign exec         = accept && (op != OP_NONE);

  always_comb begin
    mstatus_rd                                 = '0;
    mstatus_rd[MSTATUS_MIE]                    = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE]                   = mstatus_mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    old_val = '0;
    impl    = 1'b1;
    case (addr)
      CSR_MSTATUS:               old_val = mstatus_rd;
      CSR_MISA:                  old_val = MISA_VAL;
      CSR_MIE:                   old_val = mie_q;
      CSR_MTVEC:                 old_val = mtvec_q;
      CSR_MSCRATCH:              old_val = mscratch_q;
      CSR_MEPC:                  old_val = mepc_q;
      CSR_MCAUSE:                old_val = mcause_q;
      CSR_MTVAL:                 old_val = mtval_q;
      CSR_MCYCLE, CSR_CYCLE:     old_val = cycle_q[XLEN-1:0];
      CSR_MINSTRET, CSR_INSTRET: old_val = instret_q[XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH: begin
        if (XLEN == 32) old_val = xlen_t'(cycle_q[63:32]);
        else            impl    = 1'b0;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        if (XLEN == 32) old_val = xlen_t'(instret_q[63:32]);
        else            impl    = 1'b0;
      end
      CSR_MHARTID:               old_val = xlen_t'(HART_ID);
      default:                   impl    = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_RW:   new_val = src;
      OP_SET:  new_val = old_val | src;
      OP_CLR:  new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign read_only = (addr[11:10] == 2'b11) || (addr == CSR_MISA);
  assign illegal_c = !impl || (wr_try && read_only);
  assign do_write  = exec && wr_try && !illegal_c;

  // At XLEN=64 a low-address counter write covers the whole counter; at
  // XLEN=32 each half is written from the same 32-bit value.
  always_comb begin
    if (XLEN == 64) cnt_wdata = 64'(new_val);
    else            cnt_wdata = {2{new_val[31:0]}};
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (do_write && (addr == CSR_MCYCLE)),
    .wr_hi (do_write && ((addr == CSR_MCYCLEH) || ((XLEN == 64) && (addr == CSR_MCYCLE)))),
    .wdata (cnt_wdata),
    .count (cycle_q)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret_pulse),
    .wr_lo (do_write && (addr == CSR_MINSTRET)),
    .wr_hi (do_write && ((addr == CSR_MINSTRETH) || ((XLEN == 64) && (addr == CSR_MINSTRET)))),
    .wdata (cnt_wdata),
    .count (instret_q)
  );

  // Trap beats mret; neither can coincide with a CSR write because in_ready
  // is low while either is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= xlen_t'(RESET_MTVEC);
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else if (trap_valid) begin
      mepc_q         <= trap_pc & ALIGN4;
      mcause_q       <= trap_cause;
      mtval_q        <= trap_val;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (do_write) begin
      case (addr)
        CSR_MSTATUS: begin
          mstatus_mie_q  <= new_val[MSTATUS_MIE];
          mstatus_mpie_q <= new_val[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_q      <= new_val & MIE_MASK;
        CSR_MTVEC:    mtvec_q    <= new_val & ALIGN4;
        CSR_MSCRATCH: mscratch_q <= new_val;
        CSR_MEPC:     mepc_q     <= new_val & ALIGN4;
        CSR_MCAUSE:   mcause_q   <= new_val;
        CSR_MTVAL:    mtval_q    <= new_val;
        default: ;
      endcase
    end
  end

  // Single-entry result register. An accepted request without a CSR flag
  // still consumes the handshake slot, so it clears any consumed result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      rd_out_q    <= '0;
      rd_data_q   <= '0;
      out_en_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (exec) begin
      out_valid_q <= 1'b1;
      rd_out_q    <= bus.rd;
      rd_data_q   <= old_val;
      out_en_q    <= (bus.rd != 5'd0) && !illegal_c;
      illegal_q   <= illegal_c;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.rd_out    = rd_out_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.out_en    = out_en_q;
  assign bus.illegal   = illegal_q;

  assign mtvec_out  = mtvec_q;
  assign mepc_out   = mepc_q;
  assign mie_global = mstatus_mie_q;

endmodule

// File: tb/tb_ex_csr_file.sv
// tb_ex_csr_file: directed, table-driven bench for ex_csr_file (XLEN=32,
// RESET_MTVEC=0x1000, HART_ID=3), plus hand sequences for stall, trap/mret,
// counter wrap/priority, no-flag accepts and mid-handshake reset.
module tb_ex_csr_file;
  import csr_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic instret_pulse = 1'b0;
  logic trap_valid = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0, trap_val = '0;
  logic mret_valid = 1'b0;
  logic [31:0] mtvec_out, mepc_out;
  logic mie_global;

  int n_cmp = 0;
  int n_err = 0;

  ex_csr_file_if #(.XLEN(XLEN)) bus ();

  ex_csr_file #(
    .XLEN        (XLEN),
    .RESET_MTVEC (32'h0000_1000),
    .HART_ID     (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .instret_pulse (instret_pulse),
    .trap_valid    (trap_valid),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .trap_val      (trap_val),
    .mret_valid    (mret_valid),
    .mtvec_out     (mtvec_out),
    .mepc_out      (mepc_out),
    .mie_global    (mie_global)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [47:0] flags;
    logic [4:0]  rd;
    logic [4:0]  imm;
    logic [31:0] rs1;
    logic [11:0] addr;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_ill;
    logic        exp_en;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [47:0] fl(input int idx);
    logic [47:0] f;
    f = '0;
    f[idx] = 1'b1;
    return f;
  endfunction

  function automatic vec_t mk(input logic [47:0] f, input logic [4:0] rd, input logic [4:0] imm,
                              input logic [31:0] rs1, input logic [11:0] addr, input logic chk,
                              input logic [31:0] d, input logic ill, input logic en);
    vec_t v;
    v.flags = f; v.rd = rd; v.imm = imm; v.rs1 = rs1; v.addr = addr;
    v.chk_data = chk; v.exp_data = d; v.exp_ill = ill; v.exp_en = en;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer one request at a falling edge, wait (bounded) for in_ready, let it
  // be accepted at the next rising edge, then drop in_valid 1ns later.
  task automatic issue(input logic [47:0] f, input logic [4:0] rd, input logic [4:0] imm,
                       input logic [31:0] rs1, input logic [11:0] addr);
    int n;
    @(negedge clk);
    bus.inst_flags = f;
    bus.rd         = rd;
    bus.imm_1519   = imm;
    bus.rs1_data   = rs1;
    bus.imm_2031   = addr;
    bus.in_valid   = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for addr 0x%0h", addr);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_read(input string name, input logic [11:0] addr, input logic [31:0] exp);
    issue(fl(F_CSRRS), 5'd1, 5'd0, 32'hFFFF_FFFF, addr);
    check({name, " valid"}, bus.out_valid, 1'b1);
    check(name, bus.rd_data, exp);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.inst_flags = '0;
    bus.rd         = '0;
    bus.imm_1519   = '0;
    bus.rs1_data   = '0;
    bus.imm_2031   = '0;
    bus.out_ready  = 1'b1;

    //            flags          rd  imm    rs1           addr   chk data          ill en
    vecs.push_back(mk(fl(F_CSRRW),  1, 5,    32'h1234_5678, 12'h340, 1, 32'h0,         0, 1));
    vecs.push_back(mk(fl(F_CSRRS),  2, 6,    32'h0000_0001, 12'h340, 1, 32'h1234_5678, 0, 1));
    vecs.push_back(mk(fl(F_CSRRS),  3, 0,    32'hFFFF_FFFF, 12'h340, 1, 32'h1234_5679, 0, 1));
    vecs.push_back(mk(fl(F_CSRRC),  3, 7,    32'h0000_0009, 12'h340, 1, 32'h1234_5679, 0, 1));
    vecs.push_back(mk(fl(F_CSRRWI), 4, 5'h1F, 32'h0000_AAAA, 12'h340, 1, 32'h1234_5670, 0, 1));
    vecs.push_back(mk(fl(F_CSRRSI), 0, 0,    32'h0,         12'h340, 1, 32'h0000_001F, 0, 0));
    vecs.push_back(mk(fl(F_CSRRS),  5, 0,    32'h0,         12'h300, 1, 32'h0000_1800, 0, 1));
    vecs.push_back(mk(fl(F_CSRRW),  6, 1,    32'h5,         12'hC00, 0, 32'h0,         1, 0));
    vecs.push_back(mk(fl(F_CSRRS),  6, 0,    32'h0,         12'hC00, 0, 32'h0,         0, 1));
    vecs.push_back(mk(fl(F_CSRRS),  7, 0,    32'h0,         12'h7C0, 0, 32'h0,         1, 0));
    vecs.push_back(mk(fl(F_CSRRS),  7, 0,    32'h0,         12'h301, 1, 32'h4000_0100, 0, 1));
    vecs.push_back(mk(fl(F_CSRRW),  8, 1,    32'h0,         12'h301, 0, 32'h0,         1, 0));
    vecs.push_back(mk(fl(F_CSRRS),  8, 0,    32'h0,         12'hF14, 1, 32'h3,         0, 1));
    vecs.push_back(mk(fl(F_CSRRC),  8, 2,    32'h1,         12'hF14, 0, 32'h0,         1, 0));
    vecs.push_back(mk(fl(F_CSRRSI), 8, 0,    32'h0,         12'hF14, 1, 32'h3,         0, 1));
    vecs.push_back(mk(fl(F_CSRRW),  9, 1,    32'h8000_0007, 12'h305, 1, 32'h0000_1000, 0, 1));
    vecs.push_back(mk(fl(F_CSRRS),  9, 0,    32'h0,         12'h305, 1, 32'h8000_0004, 0, 1));
    vecs.push_back(mk(fl(F_CSRRW), 10, 1,    32'hFFFF_FFFF, 12'h304, 1, 32'h0,         0, 1));
    vecs.push_back(mk(fl(F_CSRRS), 10, 0,    32'h0,         12'h304, 1, 32'h0000_0888, 0, 1));
    vecs.push_back(mk(fl(F_CSRRWI),11, 8,    32'h0,         12'h300, 1, 32'h0000_1800, 0, 1));
    vecs.push_back(mk(fl(F_CSRRS), 11, 0,    32'h0,         12'h300, 1, 32'h0000_1808, 0, 1));
    vecs.push_back(mk(fl(F_CSRRW), 12, 1,    32'h0000_0103, 12'h341, 1, 32'h0,         0, 1));
    vecs.push_back(mk(fl(F_CSRRS), 12, 0,    32'h0,         12'h341, 1, 32'h0000_0100, 0, 1));
    vecs.push_back(mk(fl(F_CSRRW), 13, 1,    32'h0000_DEAD, 12'h342, 1, 32'h0,         0, 1));
    vecs.push_back(mk(fl(F_CSRRCI),13, 5'h0D, 32'h0,        12'h342, 1, 32'h0000_DEAD, 0, 1));
    vecs.push_back(mk(fl(F_CSRRS), 13, 0,    32'h0,         12'h342, 1, 32'h0000_DEA0, 0, 1));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset rd_out", bus.rd_out, 5'd0);
    check("reset rd_data", bus.rd_data, 32'h0);
    check("reset out_en", bus.out_en, 1'b0);
    check("reset illegal", bus.illegal, 1'b0);
    check("reset mtvec", mtvec_out, 32'h0000_1000);
    check("reset mepc", mepc_out, 32'h0);
    check("reset mie_global", mie_global, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Table: back-to-back accepts with out_ready held high
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].flags, vecs[i].rd, vecs[i].imm, vecs[i].rs1, vecs[i].addr);
      check($sformatf("vec%0d out_valid", i), bus.out_valid, 1'b1);
      check($sformatf("vec%0d rd_out", i), bus.rd_out, vecs[i].rd);
      check($sformatf("vec%0d illegal", i), bus.illegal, vecs[i].exp_ill);
      check($sformatf("vec%0d out_en", i), bus.out_en, vecs[i].exp_en);
      if (vecs[i].chk_data)
        check($sformatf("vec%0d rd_data", i), bus.rd_data, vecs[i].exp_data);
    end
    check("mtvec_out after write", mtvec_out, 32'h8000_0004);
    check("mepc_out after write", mepc_out, 32'h0000_0100);
    check("mie_global after write", mie_global, 1'b1);

    // Backpressure: result held for 3 cycles, next request accepted on release
    issue(fl(F_CSRRS), 5'd20, 5'd0, 32'h0, 12'h340);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.inst_flags = fl(F_CSRRWI);
    bus.rd         = 5'd21;
    bus.imm_1519   = 5'd3;
    bus.imm_2031   = 12'h340;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("stall%0d in_ready", i), bus.in_ready, 1'b0);
      check($sformatf("stall%0d out_valid", i), bus.out_valid, 1'b1);
      check($sformatf("stall%0d rd_out", i), bus.rd_out, 5'd20);
      check($sformatf("stall%0d rd_data", i), bus.rd_data, 32'h0000_001F);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("release out_valid", bus.out_valid, 1'b1);
    check("release rd_out", bus.rd_out, 5'd21);
    check("release rd_data", bus.rd_data, 32'h0000_001F);
    expect_read("mscratch after stall", 12'h340, 32'h0000_0003);

    // Trap with MIE=1
    @(negedge clk);
    trap_valid = 1'b1;
    trap_cause = 32'hB;
    trap_pc    = 32'h8000_0102;
    trap_val   = 32'h55;
    #1;
    check("trap in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    check("trap mepc", mepc_out, 32'h8000_0100);
    check("trap mie_global", mie_global, 1'b0);
    expect_read("trap mstatus", 12'h300, 32'h0000_1880);
    expect_read("trap mcause", 12'h342, 32'h0000_000B);
    expect_read("trap mtval", 12'h343, 32'h0000_0055);

    // mret restores MIE from MPIE
    @(negedge clk);
    mret_valid = 1'b1;
    @(posedge clk);
    #1;
    mret_valid = 1'b0;
    check("mret mie_global", mie_global, 1'b1);
    expect_read("mret mstatus", 12'h300, 32'h0000_1888);

    // Trap and mret together: trap wins
    @(negedge clk);
    trap_valid = 1'b1;
    mret_valid = 1'b1;
    trap_pc    = 32'h0000_0200;
    trap_cause = 32'h3;
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    check("trap+mret mie_global", mie_global, 1'b0);
    check("trap+mret mepc", mepc_out, 32'h0000_0200);
    expect_read("trap+mret mstatus", 12'h300, 32'h0000_1880);

    // mcycle low-half wrap carries into the high half
    issue(fl(F_CSRRW), 5'd1, 5'd1, 32'h0, 12'hB80);
    issue(fl(F_CSRRW), 5'd1, 5'd1, 32'hFFFF_FFFF, 12'hB00);
    expect_read("mcycle after write", 12'hB00, 32'hFFFF_FFFF);
    expect_read("mcycleh after wrap", 12'hB80, 32'h0000_0001);
    expect_read("cycleh alias", 12'hC80, 32'h0000_0001);

    // minstret write wins over a simultaneous retire pulse
    instret_pulse = 1'b1;
    issue(fl(F_CSRRW), 5'd1, 5'd1, 32'h0000_0050, 12'hB02);
    instret_pulse = 1'b0;
    check("minstret old value", bus.rd_data, 32'h0);
    expect_read("minstret written", 12'hB02, 32'h0000_0050);
    instret_pulse = 1'b1;
    @(posedge clk);
    #1;
    instret_pulse = 1'b0;
    expect_read("minstret incremented", 12'hB02, 32'h0000_0051);
    expect_read("instret alias", 12'hC02, 32'h0000_0051);
    expect_read("minstreth", 12'hB82, 32'h0);

    // Accept without any CSR flag produces nothing and changes nothing
    issue(fl(0), 5'd1, 5'd5, 32'hFFFF_FFFF, 12'h340);
    check("noflag out_valid", bus.out_valid, 1'b0);
    expect_read("noflag mscratch", 12'h340, 32'h0000_0003);

    // Asynchronous reset while a result is held
    issue(fl(F_CSRRS), 5'd9, 5'd0, 32'h0, 12'h340);
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midreset out_valid", bus.out_valid, 1'b0);
    check("midreset out_en", bus.out_en, 1'b0);
    check("midreset mtvec", mtvec_out, 32'h0000_1000);
    check("midreset mepc", mepc_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    expect_read("post-reset mscratch", 12'h340, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_csr_file.md
# ex_csr_file

Parametrised CSR execution unit and machine-mode CSR file for the RV core's EX stage. Executes CSRRW/S/C and immediate variants with correct set/clear semantics and x0 write suppression. Holds the M-mode CSR state, including 64-bit cycle/instret counters and trap/mret entry updates. It replaces the combinational CSR path with a registered, valid/ready-handshaked single-entry result stage.

## Interface
- XLEN, 32: datapath width; only 32 or 64 are legal values. At 64 the high-half counter CSRs are illegal.
- RESET_MTVEC, 32'h0000_0000: mtvec value on reset.
- HART_ID, 0: value returned by mhartid.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  CSR instruction offered.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- inst_flags  in  48  decoded one-hot flags: [37] csrrc, [38] csrrci, [39] csrrs, [40] csrrsi, [41] csrrw, [42] csrrwi.
- rd  in  5  destination register.
- imm_1519  in  5  rs1 index, or zimm for the immediate forms.
- rs1_data  in  XLEN  rs1 value.
- imm_2031  in  12  CSR address.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts the result.
- rd_out  out  5  destination register.
- rd_data  out  XLEN  old CSR value.
- out_en  out  1  register-file write enable.
- illegal  out  1  illegal-instruction result.
- instret_pulse  in  1  one instruction retired this cycle.
- trap_valid  in  1  take trap.
- trap_cause  in  XLEN  cause value.
- trap_pc  in  XLEN  faulting pc.
- trap_val  in  XLEN  tval.
- mret_valid  in  1  execute mret.
- mtvec_out  out  XLEN  trap vector.
- mepc_out  out  XLEN  return pc.
- mie_global  out  1  mstatus.MIE.

## Operation
**Handshake**
- in_ready = !trap_valid && !mret_valid && (!out_valid || out_ready).
- An accept with no CSR flag set is ignored: no result is produced and no state changes.

**Operand and new value**
- src = rs1_data for the register forms; src = zero-extended imm_1519 for the immediate forms.
- csrrw/wi: new = src.
- csrrs/si: new = old | src.
- csrrc/ci: new = old & ~src.

**Write and read rules**
- A write is attempted for csrrw/wi always, and for set/clear forms only if imm_1519 != 0.
- rd_data = old value, where old is the CSR value in the accept cycle.
- out_en = (rd != 0) && !illegal.

**Illegal result**
- illegal = 1 when the address is unimplemented, or when a write is attempted to a read-only address (imm_2031[11:10] == 2'b11, or misa).
- On an illegal result no CSR changes and out_en = 0.

**Implemented CSRs (address: writable bits)**
- mstatus 0x300: MIE bit 3, MPIE bit 7. MPP [12:11] reads 2'b11.
- misa 0x301: read-only constant, RV32I or RV64I per XLEN.
- mie 0x304: bits 3, 7, 11.
- mtvec 0x305: bits [1:0] forced to 0.
- mscratch 0x340: all bits writable.
- mepc 0x341: bits [1:0] forced to 0.
- mcause 0x342, mtval 0x343: all bits writable.
- mcycle 0xB00 / minstret 0xB02, plus the XLEN=32 high halves 0xB80 / 0xB82.
- Read-only aliases cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82.
- mhartid 0xF14: read-only, returns HART_ID.

**Counters**
- Counters are 64-bit. mcycle increments every cycle.
- minstret increments when instret_pulse = 1.
- A CSR write to either half in the same cycle wins over the increment; the written half takes the written value and the other half holds.
- The unwritten counter is unaffected by a write to the other counter.

**Trap and mret**
- Trap: mepc <= trap_pc with [1:0] cleared, mcause <= trap_cause, mtval <= trap_val, MPIE <= MIE, MIE <= 0.
- mret: MIE <= MPIE, MPIE <= 1.
- If trap_valid and mret_valid are both set, trap wins.
- Neither trap nor mret clears a result already held in the output stage.

**Reset (rst low, asynchronous)**
- out_valid = 0, rd_out = 0, rd_data = 0, out_en = 0, illegal = 0.
- mstatus MIE = MPIE = 0; mie, mscratch, mepc, mcause, mtval = 0.
- mtvec = RESET_MTVEC; counters = 0.
- Reset mid-handshake drops the held result.

## Timing
- Latency: accept at edge N gives out_valid = 1 after edge N, held stable until out_valid && out_ready.
- CSR state updates at the accept edge, so back-to-back instructions see the prior write with no bubble.
- Full throughput: one instruction per cycle when out_ready = 1.
- out_en, rd_out, rd_data and illegal are valid only while out_valid = 1.
- Trap and mret updates take effect at the edge where they are asserted. mtvec_out, mepc_out and mie_global are registered-state outputs.
- A counter read returns the pre-increment value of the accept cycle.

## Structure
- Package csr_pkg holds:
  - CSR address constants;
  - mstatus/mie field bit positions;
  - inst_flags bit indices 37–42;
  - the misa constants.
- Sub-module csr_counter64 is natural, instantiated twice (mcycle, minstret):
  - 64-bit counter with inc, wr_lo, wr_hi and wdata inputs;
  - write-over-increment priority.

## Test plan
- csrrw mscratch with rs1 = 0x1234_5678, then csrrs mscratch with rs1 = 0x0000_0001: rd_data values 0 then 0x1234_5678; mscratch ends at 0x1234_5679.
- csrrs mstatus with rs1 index 0 (imm_1519 = 0): no write and illegal = 0. csrrw to 0xC00: illegal = 1, out_en = 0.
- out_ready held low for 3 cycles: in_ready = 0 and the output is stable; releasing it lets the next instruction accept the following cycle.
- trap with cause 0xB and pc 0x8000_0102 while MIE = 1: mepc = 0x8000_0100, MIE = 0, MPIE = 1. mret then restores MIE = 1.
- Write mcycle = 0xFFFF_FFFF: the next read of mcycleh increments by 1 after the wrap. A simultaneous instret_pulse with a minstret write leaves minstret = the written value.
- Assert rst low while out_valid = 1: out_valid and out_en drop immediately, mtvec = RESET_MTVEC.
